// File: rtl/maxpool_cu_pkg.sv
// maxpool_pkg: FSM and window-phase encodings plus width helpers shared by maxpool_cu
// and pool_window_reduce.
package maxpool_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'b00,
      READ      = 2'b01,
      DRAIN     = 2'b10,
      WAIT_NEXT = 2'b11
   } state_t;

   // Phase bit 1 selects the window row (dr), bit 0 selects the window column (dc).
   localparam logic [1:0] PHASE_00 = 2'd0;
   localparam logic [1:0] PHASE_01 = 2'd1;
   localparam logic [1:0] PHASE_10 = 2'd2;
   localparam logic [1:0] PHASE_11 = 2'd3;

   function automatic int addr_width(input int side, input int depth);
      return (side * side * depth > 1) ? $clog2(side * side * depth) : 1;
   endfunction

   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/maxpool_cu_window_reduce.sv
// pool_window_reduce: folds the four samples of a 2x2 window into one registered result.
// Max pooling by default; define AVG_POOL_EN for floor-average pooling.
module pool_window_reduce
   import maxpool_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] data,
   input  logic                  valid,
   input  logic                  first,
   input  logic                  last,
   output logic [DATA_WIDTH-1:0] result,
   output logic                  result_valid
);

`ifdef AVG_POOL_EN
   // Two guard bits hold the sum of four samples without overflow.
   logic signed [DATA_WIDTH+1:0] acc;
   logic signed [DATA_WIDTH+1:0] sample;
   logic signed [DATA_WIDTH+1:0] next_acc;
   logic        [DATA_WIDTH-1:0] result_next;

   always_comb begin
      sample      = {{2{data[DATA_WIDTH-1]}}, data};
      next_acc    = first ? sample : acc + sample;
      // Dropping the two low bits of a signed sum is floor division by 4.
      result_next = next_acc[DATA_WIDTH+1:2];
   end
`else
   logic signed [DATA_WIDTH-1:0] acc;
   logic signed [DATA_WIDTH-1:0] sample;
   logic signed [DATA_WIDTH-1:0] next_acc;
   logic        [DATA_WIDTH-1:0] result_next;

   always_comb begin
      sample = $signed(data);
      if (first) begin
         next_acc = sample;
      end else begin
         next_acc = (sample > acc) ? sample : acc;
      end
      result_next = next_acc;
   end
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc          <= '0;
         result       <= '0;
         result_valid <= 1'b0;
      end else begin
         if (valid) begin
            acc <= next_acc;
         end
         if (valid && last) begin
            result <= result_next;
         end
         result_valid <= valid && last;
      end
   end

endmodule

// File: rtl/maxpool_cu.sv
// maxpool_cu: 2x2 stride-2 pooling control unit between conv and next stage.
// Max pooling by default; AVG_POOL_EN selects average pooling in pool_window_reduce.
module maxpool_cu
   import maxpool_pkg::*;
#(
   parameter int DATA_WIDTH            = 32,
   parameter int IFM_SIZE              = 28,
   parameter int IFM_DEPTH             = 6,
   parameter int IFM_SIZE_NEXT         = IFM_SIZE / 2,
   parameter int ADDRESS_SIZE_IFM      = addr_width(IFM_SIZE, IFM_DEPTH),
   parameter int ADDRESS_SIZE_NEXT_IFM = addr_width(IFM_SIZE_NEXT, IFM_DEPTH)
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             start_from_previous,
   output logic                             end_to_previous,
   output logic                             ifm_enable_read,
   output logic [ADDRESS_SIZE_IFM-1:0]      ifm_address_read,
   input  logic [DATA_WIDTH-1:0]            ifm_data_in,
   output logic                             ifm_enable_write_next,
   output logic [ADDRESS_SIZE_NEXT_IFM-1:0] ifm_address_write_next,
   output logic [DATA_WIDTH-1:0]            ifm_data_out,
   input  logic                             end_from_next,
   output logic                             start_to_next
);

   localparam int CH_W = cnt_width(IFM_DEPTH);
   localparam int RC_W = cnt_width(IFM_SIZE_NEXT);
   localparam logic [CH_W-1:0] CH_MAX = CH_W'(IFM_DEPTH - 1);
   localparam logic [RC_W-1:0] RC_MAX = RC_W'(IFM_SIZE_NEXT - 1);

   state_t state;

   logic [CH_W-1:0] ch, nxt_ch;
   logic [RC_W-1:0] row, nxt_row;
   logic [RC_W-1:0] col, nxt_col;
   logic [1:0]      phase, nxt_phase;
   logic            last_read;
   logic            drain_cnt;

   logic [ADDRESS_SIZE_IFM-1:0]      rd_addr_next;
   logic [ADDRESS_SIZE_NEXT_IFM-1:0] wr_addr;

   logic                             rd_valid_d1;
   logic                             first_d1;
   logic                             last_d1;
   logic [ADDRESS_SIZE_NEXT_IFM-1:0] waddr_d1;

   always_comb begin
      nxt_phase = phase + 2'd1;
      nxt_col   = col;
      nxt_row   = row;
      nxt_ch    = ch;
      if (phase == PHASE_11) begin
         if (col == RC_MAX) begin
            nxt_col = '0;
            if (row == RC_MAX) begin
               nxt_row = '0;
               nxt_ch  = (ch == CH_MAX) ? '0 : ch + 1'b1;
            end else begin
               nxt_row = row + 1'b1;
            end
         end else begin
            nxt_col = col + 1'b1;
         end
      end

      last_read = (phase == PHASE_11) && (col == RC_MAX) && (row == RC_MAX) && (ch == CH_MAX);

      rd_addr_next = ADDRESS_SIZE_IFM'(int'(nxt_ch) * IFM_SIZE * IFM_SIZE
                     + (2 * int'(nxt_row) + int'(nxt_phase[1])) * IFM_SIZE
                     + 2 * int'(nxt_col) + int'(nxt_phase[0]));

      wr_addr = ADDRESS_SIZE_NEXT_IFM'(int'(ch) * IFM_SIZE_NEXT * IFM_SIZE_NEXT
                + int'(row) * IFM_SIZE_NEXT + int'(col));
   end

   assign end_to_previous = (state == IDLE);
   assign start_to_next   = (state == WAIT_NEXT) && end_from_next;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state                  <= IDLE;
         ch                     <= '0;
         row                    <= '0;
         col                    <= '0;
         phase                  <= '0;
         drain_cnt              <= 1'b0;
         ifm_enable_read        <= 1'b0;
         ifm_address_read       <= '0;
         rd_valid_d1            <= 1'b0;
         first_d1               <= 1'b0;
         last_d1                <= 1'b0;
         waddr_d1               <= '0;
         ifm_address_write_next <= '0;
      end else begin
         // Window tags travel alongside the RAM latency; the write address reaches the port
         // on the same edge that the reducer registers the window result.
         rd_valid_d1 <= ifm_enable_read;
         first_d1    <= (phase == PHASE_00);
         last_d1     <= (phase == PHASE_11);
         waddr_d1    <= wr_addr;
         if (rd_valid_d1 && last_d1) begin
            ifm_address_write_next <= waddr_d1;
         end

         case (state)
            IDLE: begin
               if (start_from_previous) begin
                  state            <= READ;
                  ifm_enable_read  <= 1'b1;
                  ifm_address_read <= '0;
               end
            end
            READ: begin
               ch               <= nxt_ch;
               row              <= nxt_row;
               col              <= nxt_col;
               phase            <= nxt_phase;
               ifm_address_read <= rd_addr_next;
               if (last_read) begin
                  ifm_enable_read <= 1'b0;
                  state           <= DRAIN;
               end
            end
            DRAIN: begin
               if (drain_cnt) begin
                  drain_cnt <= 1'b0;
                  state     <= WAIT_NEXT;
               end else begin
                  drain_cnt <= 1'b1;
               end
            end
            WAIT_NEXT: begin
               if (end_from_next) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   pool_window_reduce #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_reduce (
      .clk          (clk),
      .reset        (reset),
      .data         (ifm_data_in),
      .valid        (rd_valid_d1),
      .first        (first_d1),
      .last         (last_d1),
      .result       (ifm_data_out),
      .result_valid (ifm_enable_write_next)
   );

endmodule

// File: tb/tb_maxpool_cu.sv
// tb_maxpool_cu: cycle-accurate directed/random bench for maxpool_cu (IFM_SIZE=4, IFM_DEPTH=2).
module tb_maxpool_cu;

   localparam int DW    = 32;
   localparam int SZ    = 4;
   localparam int DEP   = 2;
   localparam int SN    = SZ / 2;
   localparam int AW    = $clog2(SZ * SZ * DEP);
   localparam int AWN   = $clog2(SN * SN * DEP);
   localparam int NREAD = 4 * SN * SN * DEP;
   localparam int NWIN  = SN * SN * DEP;

   logic           clk = 1'b0;
   logic           reset = 1'b0;
   logic           start_from_previous = 1'b0;
   logic           end_to_previous;
   logic           ifm_enable_read;
   logic [AW-1:0]  ifm_address_read;
   logic [DW-1:0]  ifm_data_in;
   logic           ifm_enable_write_next;
   logic [AWN-1:0] ifm_address_write_next;
   logic [DW-1:0]  ifm_data_out;
   logic           end_from_next = 1'b1;
   logic           start_to_next;

   logic [DW-1:0] mem [SZ*SZ*DEP];
   int            base_seq [16] = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};
   int            tests = 0;
   int            fails = 0;

   always #5 clk = ~clk;

   // Input bank: synchronous read, data one cycle after the strobe.
   always @(posedge clk) begin
      if (ifm_enable_read) ifm_data_in <= mem[ifm_address_read];
   end

   maxpool_cu #(
      .DATA_WIDTH (DW),
      .IFM_SIZE   (SZ),
      .IFM_DEPTH  (DEP)
   ) dut (
      .clk                    (clk),
      .reset                  (reset),
      .start_from_previous    (start_from_previous),
      .end_to_previous        (end_to_previous),
      .ifm_enable_read        (ifm_enable_read),
      .ifm_address_read       (ifm_address_read),
      .ifm_data_in            (ifm_data_in),
      .ifm_enable_write_next  (ifm_enable_write_next),
      .ifm_address_write_next (ifm_address_write_next),
      .ifm_data_out           (ifm_data_out),
      .end_from_next          (end_from_next),
      .start_to_next          (start_to_next)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      tests++;
      assert (obs === exp_v) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   function automatic int rd_ref(input int i);
      return base_seq[i % 16] + 16 * (i / 16);
   endfunction

   // Reference pooled value for window j (channel-major, then row, then column).
   function automatic logic [DW-1:0] window_ref(input int j);
      int     ch = j / (SN * SN);
      int     r  = (j % (SN * SN)) / SN;
      int     c  = j % SN;
      longint v [4];
      longint acc;
      for (int p = 0; p < 4; p++)
         v[p] = longint'($signed(mem[ch * SZ * SZ + (2 * r + p / 2) * SZ + 2 * c + p % 2]));
`ifdef AVG_POOL_EN
      acc = (v[0] + v[1] + v[2] + v[3]) / 4;
      if ((v[0] + v[1] + v[2] + v[3]) % 4 != 0 && (v[0] + v[1] + v[2] + v[3]) < 0) acc = acc - 1;
`else
      acc = v[0];
      for (int p = 1; p < 4; p++) if (v[p] > acc) acc = v[p];
`endif
      return DW'(acc);
   endfunction

   task automatic check_idle_outputs(input string tag);
      check({tag, "_etp"}, 64'(end_to_previous), 64'(1));
      check({tag, "_rd_en"}, 64'(ifm_enable_read), 64'(0));
      check({tag, "_rd_addr"}, 64'(ifm_address_read), 64'(0));
      check({tag, "_wr_en"}, 64'(ifm_enable_write_next), 64'(0));
      check({tag, "_wr_addr"}, 64'(ifm_address_write_next), 64'(0));
      check({tag, "_data"}, 64'(ifm_data_out), 64'(0));
      check({tag, "_stn"}, 64'(start_to_next), 64'(0));
   endtask

   // Called at a negedge while idle; returns at the negedge of the first idle cycle after the frame.
   task automatic run_frame(input int bp, input bit mid_pulse);
      int j;
      check("frame_ready_etp", 64'(end_to_previous), 64'(1));
      start_from_previous = 1'b1;
      end_from_next = (bp == 0);
      for (int k = 1; k <= NREAD + 2; k++) begin
         @(negedge clk);
         start_from_previous = mid_pulse && (k == 3);
         if (k <= NREAD) begin
            check("rd_en", 64'(ifm_enable_read), 64'(1));
            check("rd_addr", 64'(ifm_address_read), 64'(rd_ref(k - 1)));
         end else begin
            check("rd_en_drain", 64'(ifm_enable_read), 64'(0));
         end
         if (k >= 6 && (k - 6) % 4 == 0) begin
            j = (k - 6) / 4;
            check("wr_en", 64'(ifm_enable_write_next), 64'(1));
            check("wr_addr", 64'(ifm_address_write_next), 64'(j));
            check("wr_data", 64'(ifm_data_out), 64'(window_ref(j)));
         end else begin
            check("wr_en_idle", 64'(ifm_enable_write_next), 64'(0));
         end
         check("etp_busy", 64'(end_to_previous), 64'(0));
         check("stn_busy", 64'(start_to_next), 64'(0));
      end
      for (int w = 0; w <= bp; w++) begin
         @(negedge clk);
         if (w == 2) start_from_previous = 1'b1;
         if (w == 3) start_from_previous = 1'b0;
         check("wait_rd_en", 64'(ifm_enable_read), 64'(0));
         check("wait_wr_en", 64'(ifm_enable_write_next), 64'(0));
         check("wait_etp", 64'(end_to_previous), 64'(0));
         if (w == bp) begin
            end_from_next = 1'b1;
            #1;
            check("stn_pulse", 64'(start_to_next), 64'(1));
         end else begin
            check("stn_held", 64'(start_to_next), 64'(0));
         end
      end
      @(negedge clk);
      start_from_previous = 1'b0;
      check("post_stn", 64'(start_to_next), 64'(0));
      check("post_etp", 64'(end_to_previous), 64'(1));
      check("post_rd_en", 64'(ifm_enable_read), 64'(0));
   endtask

   initial begin
      for (int i = 0; i < SZ * SZ * DEP; i++) mem[i] = DW'(i);

      repeat (3) @(negedge clk);
      #1;
      check_idle_outputs("reset");
      reset = 1'b1;
      @(negedge clk);

      // Identity data: channel 0 pools to 5,7,13,15 in max mode.
      run_frame(0, 1'b0);
      // Back-to-back start in the first idle cycle, with an ignored pulse mid-READ.
      run_frame(0, 1'b1);

      // Wide random signed data plus the directed signed windows, then backpressure.
      for (int i = 0; i < SZ * SZ * DEP; i++) mem[i] = DW'($urandom);
      mem[0] = DW'(-5);
      mem[1] = DW'(-5);
      mem[4] = DW'(-1);
      mem[5] = DW'(-5);
      mem[2] = DW'(1);
      mem[3] = DW'(1);
      mem[6] = DW'(1);
      mem[7] = DW'(2);
      run_frame(10, 1'b0);

      // Narrow random range forces ties and negative values; no stale accumulator allowed.
      for (int i = 0; i < SZ * SZ * DEP; i++) mem[i] = DW'(int'($urandom_range(0, 7)) - 4);
      run_frame(0, 1'b0);

      // Reset asserted at cycle 8 of a frame, released at cycle 10.
      start_from_previous = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         start_from_previous = 1'b0;
      end
      reset = 1'b0;
      #1;
      check_idle_outputs("midreset_c8");
      @(negedge clk);
      check_idle_outputs("midreset_c9");
      reset = 1'b1;
      @(negedge clk);
      check_idle_outputs("after_reset");
      run_frame(0, 1'b0);

      for (int i = 0; i < SZ * SZ * DEP; i++) mem[i] = DW'($urandom);
      run_frame(3, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
